// File: rtl/ysyx_23060184_pkg.sv
// Shared definitions for the ysyx_23060184 LSU.
// Contents:
//   lsu_state_e   - LSU FSM state encoding
//   MemOp*        - funct3 width/sign codes for loads and stores
//   AxiRespOkay   - AXI OKAY response code
//   is_misaligned - misalignment check, only referenced when YSYX_LSU_MISALIGN_EN is defined
package ysyx_23060184_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StRaddr,
        StRdata,
        StWrite,
        StWresp,
        StDone
    } lsu_state_e;

    localparam logic [2:0] MemOpLb  = 3'b000;
    localparam logic [2:0] MemOpLh  = 3'b001;
    localparam logic [2:0] MemOpLw  = 3'b010;
    localparam logic [2:0] MemOpLbu = 3'b100;
    localparam logic [2:0] MemOpLhu = 3'b101;
    localparam logic [2:0] MemOpSb  = 3'b000;
    localparam logic [2:0] MemOpSh  = 3'b001;
    localparam logic [2:0] MemOpSw  = 3'b010;

    localparam logic [1:0] AxiRespOkay = 2'b00;

    // Halfwords need addr[0]=0, words need addr[1:0]=0; byte ops never fault.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] addr_lo,
                                           input logic is_store);
        logic mis;
        mis = 1'b0;
        if (is_store) begin
            if (op == MemOpSh) mis = addr_lo[0];
            else if (op == MemOpSw) mis = |addr_lo;
        end else begin
            if (op == MemOpLh || op == MemOpLhu) mis = addr_lo[0];
            else if (op == MemOpLw) mis = |addr_lo;
        end
        return mis;
    endfunction

endpackage

// File: rtl/ysyx_23060184_lsu_align.sv
// Combinational lane steering for the LSU.
// Ports:
//   addr_lo   in  2   low address bits of the access
//   mem_op    in  3   funct3 width/sign code
//   load_raw  in  32  raw read data word from the bus
//   store_raw in  32  store data (rs2)
//   load_data out 32  selected and extended load result
//   wstrb     out 4   write byte strobes
//   wdata     out 32  store data replicated onto all lanes
// Misaligned halves/words are steered by the truncated lane (addr[0] / addr[1:0] ignored).
module ysyx_23060184_lsu_align
    import ysyx_23060184_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  mem_op,
    input  logic [31:0] load_raw,
    input  logic [31:0] store_raw,
    output logic [31:0] load_data,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'h00;
        unique case (addr_lo)
            2'b00: byte_sel = load_raw[7:0];
            2'b01: byte_sel = load_raw[15:8];
            2'b10: byte_sel = load_raw[23:16];
            2'b11: byte_sel = load_raw[31:24];
            default: byte_sel = 8'h00;
        endcase
        half_sel = addr_lo[1] ? load_raw[31:16] : load_raw[15:0];

        load_data = load_raw;
        case (mem_op)
            MemOpLb:  load_data = {{24{byte_sel[7]}}, byte_sel};
            MemOpLh:  load_data = {{16{half_sel[15]}}, half_sel};
            MemOpLbu: load_data = {24'h0, byte_sel};
            MemOpLhu: load_data = {16'h0, half_sel};
            default:  load_data = load_raw;
        endcase
    end

    always_comb begin
        wstrb = 4'b1111;
        wdata = store_raw;
        case (mem_op)
            MemOpSb: begin
                wstrb = 4'b0001 << addr_lo;
                wdata = {4{store_raw[7:0]}};
            end
            MemOpSh: begin
                wstrb = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata = {2{store_raw[15:0]}};
            end
            default: begin
                wstrb = 4'b1111;
                wdata = store_raw;
            end
        endcase
    end

endmodule

// File: rtl/ysyx_23060184_lsu.sv
// Memory-access stage: takes the execute result over Evalid/Mready, performs a load or store
// on a simplified AXI4-Lite master port, and hands the result to write-back over Mvalid/Wready.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   Evalid/Mready             upstream handshake; ALUResult, WriteData, MemRead, MemWrite, MemOp
//   Mvalid/Wready             downstream handshake; MemResult, MemErr
//   araddr/arvalid/arready    read address channel
//   rdata/rresp/rvalid/rready read data channel
//   awaddr/awvalid/awready    write address channel
//   wdata/wstrb/wvalid/wready write data channel
//   bresp/bvalid/bready       write response channel
// Optional: define YSYX_LSU_MISALIGN_EN to fault misaligned accesses without touching the bus.
module ysyx_23060184_lsu
    import ysyx_23060184_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  Evalid,
    output logic                  Mready,
    input  logic [DATA_WIDTH-1:0] ALUResult,
    input  logic [DATA_WIDTH-1:0] WriteData,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [2:0]            MemOp,
    output logic                  Mvalid,
    input  logic                  Wready,
    output logic [DATA_WIDTH-1:0] MemResult,
    output logic                  MemErr,
    output logic [DATA_WIDTH-1:0] araddr,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    output logic [DATA_WIDTH-1:0] awaddr,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_WIDTH-1:0] wdata,
    output logic [3:0]            wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    lsu_state_e            state;
    logic [DATA_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] store_data;
    logic [2:0]            op;
    logic                  aw_done;
    logic                  w_done;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  aw_hs;
    logic                  w_hs;

    ysyx_23060184_lsu_align u_align (
        .addr_lo   (addr[1:0]),
        .mem_op    (op),
        .load_raw  (rdata),
        .store_raw (store_data),
        .load_data (load_data),
        .wstrb     (wstrb),
        .wdata     (wdata)
    );

    // Latched address is the only source, so both address channels are stable while valid.
    assign araddr = addr;
    assign awaddr = addr;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= StIdle;
            addr       <= '0;
            store_data <= '0;
            op         <= MemOpLb;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
            Mready     <= 1'b1;
            Mvalid     <= 1'b0;
            MemResult  <= '0;
            MemErr     <= 1'b0;
            arvalid    <= 1'b0;
            rready     <= 1'b0;
            awvalid    <= 1'b0;
            wvalid     <= 1'b0;
            bready     <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (Evalid && Mready) begin
                        addr       <= ALUResult;
                        store_data <= WriteData;
                        op         <= MemOp;
                        MemErr     <= 1'b0;
                        Mready     <= 1'b0;
`ifdef YSYX_LSU_MISALIGN_EN
                        if ((MemRead || MemWrite) &&
                            is_misaligned(MemOp, ALUResult[1:0], !MemRead)) begin
                            state     <= StDone;
                            Mvalid    <= 1'b1;
                            MemErr    <= 1'b1;
                            MemResult <= MemRead ? '0 : ALUResult;
                        end else
`endif
                        if (MemRead) begin
                            // Load wins when MemRead and MemWrite are both set.
                            state   <= StRaddr;
                            arvalid <= 1'b1;
                        end else if (MemWrite) begin
                            state   <= StWrite;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            aw_done <= 1'b0;
                            w_done  <= 1'b0;
                        end else begin
                            state     <= StDone;
                            Mvalid    <= 1'b1;
                            MemResult <= ALUResult;
                        end
                    end
                end
                StRaddr: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= StRdata;
                    end
                end
                StRdata: begin
                    if (rvalid) begin
                        rready    <= 1'b0;
                        MemResult <= load_data;
                        MemErr    <= (rresp != AxiRespOkay);
                        Mvalid    <= 1'b1;
                        state     <= StDone;
                    end
                end
                StWrite: begin
                    if (aw_hs) begin
                        awvalid <= 1'b0;
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        wvalid <= 1'b0;
                        w_done <= 1'b1;
                    end
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        bready <= 1'b1;
                        state  <= StWresp;
                    end
                end
                StWresp: begin
                    if (bvalid) begin
                        bready    <= 1'b0;
                        MemErr    <= (bresp != AxiRespOkay);
                        MemResult <= addr;
                        Mvalid    <= 1'b1;
                        state     <= StDone;
                    end
                end
                StDone: begin
                    if (Wready) begin
                        Mvalid <= 1'b0;
                        Mready <= 1'b1;
                        state  <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_23060184_lsu.sv
// Directed self-checking bench for ysyx_23060184_lsu. Inputs are driven and outputs sampled on
// the falling clock edge; the DUT acts on the rising edge.
// Build with YSYX_LSU_MISALIGN_EN defined to exercise the misalignment fault path.
module tb_ysyx_23060184_lsu;
    import ysyx_23060184_pkg::*;

    logic        clk;
    logic        rstn;
    logic        Evalid;
    logic        Mready;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  MemOp;
    logic        Mvalid;
    logic        Wready;
    logic [31:0] MemResult;
    logic        MemErr;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    int checks = 0;
    int passed = 0;

    ysyx_23060184_lsu #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .Evalid    (Evalid),
        .Mready    (Mready),
        .ALUResult (ALUResult),
        .WriteData (WriteData),
        .MemRead   (MemRead),
        .MemWrite  (MemWrite),
        .MemOp     (MemOp),
        .Mvalid    (Mvalid),
        .Wready    (Wready),
        .MemResult (MemResult),
        .MemErr    (MemErr),
        .araddr    (araddr),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rvalid    (rvalid),
        .rready    (rready),
        .awaddr    (awaddr),
        .awvalid   (awvalid),
        .awready   (awready),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .wvalid    (wvalid),
        .wready    (wready),
        .bresp     (bresp),
        .bvalid    (bvalid),
        .bready    (bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // One load: ar_dly idle cycles before arready, r_dly before rvalid, w_dly before Wready.
    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] op,
                           input logic also_write, input logic [31:0] rd, input logic [1:0] resp,
                           input int ar_dly, input int r_dly, input int w_dly, input logic hold_ev,
                           input logic [31:0] exp_res, input logic exp_err);
        Evalid = 1'b1; ALUResult = addr; MemRead = 1'b1; MemWrite = also_write; MemOp = op;
        WriteData = 32'h5555_AAAA;
        tick();
        if (!hold_ev) Evalid = 1'b0;
        ALUResult = 32'hDEAD_0000;
        for (int i = 0; i < ar_dly; i++) begin
            check({tag, "_arvalid_hold"}, arvalid, 1);
            check({tag, "_araddr_hold"}, araddr, addr);
            check({tag, "_mready_busy"}, Mready, 0);
            tick();
        end
        check({tag, "_arvalid"}, arvalid, 1);
        check({tag, "_araddr"}, araddr, addr);
        check({tag, "_awvalid_idle"}, awvalid, 0);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check({tag, "_arvalid_drop"}, arvalid, 0);
        for (int i = 0; i < r_dly; i++) begin
            check({tag, "_rready_hold"}, rready, 1);
            check({tag, "_mvalid_early"}, Mvalid, 0);
            check({tag, "_mready_rbusy"}, Mready, 0);
            tick();
        end
        check({tag, "_rready"}, rready, 1);
        rvalid = 1'b1; rdata = rd; rresp = resp;
        tick();
        rvalid = 1'b0; rdata = 32'h0; rresp = 2'b00;
        check({tag, "_rready_drop"}, rready, 0);
        for (int i = 0; i < w_dly; i++) begin
            check({tag, "_mvalid_hold"}, Mvalid, 1);
            check({tag, "_result_hold"}, MemResult, exp_res);
            check({tag, "_mready_done"}, Mready, 0);
            tick();
        end
        check({tag, "_mvalid"}, Mvalid, 1);
        check({tag, "_result"}, MemResult, exp_res);
        check({tag, "_err"}, MemErr, exp_err);
        Wready = 1'b1; Evalid = 1'b0;
        tick();
        Wready = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        check({tag, "_mvalid_end"}, Mvalid, 0);
        check({tag, "_mready_end"}, Mready, 1);
    endtask

    // One store: awready after aw_dly cycles, wready after w_dly cycles, bvalid after b_dly.
    task automatic do_store(input string tag, input logic [31:0] addr, input logic [2:0] op,
                            input logic [31:0] wd, input int aw_dly, input int w_dly,
                            input int b_dly, input logic [1:0] resp, input logic [3:0] exp_strb,
                            input logic [31:0] exp_wdata, input logic exp_err);
        int n;
        n = (aw_dly > w_dly) ? aw_dly : w_dly;
        Evalid = 1'b1; ALUResult = addr; MemRead = 1'b0; MemWrite = 1'b1; MemOp = op;
        WriteData = wd;
        tick();
        Evalid = 1'b0; ALUResult = 32'h0; WriteData = 32'h0;
        for (int c = 0; c <= n; c++) begin
            awready = (c == aw_dly);
            wready  = (c == w_dly);
            check({tag, "_awvalid"}, awvalid, c <= aw_dly);
            check({tag, "_wvalid"}, wvalid, c <= w_dly);
            check({tag, "_arvalid_idle"}, arvalid, 0);
            if (c <= aw_dly) check({tag, "_awaddr"}, awaddr, addr);
            if (c <= w_dly) begin
                check({tag, "_wstrb"}, wstrb, exp_strb);
                check({tag, "_wdata"}, wdata, exp_wdata);
            end
            tick();
        end
        awready = 1'b0; wready = 1'b0;
        check({tag, "_awvalid_drop"}, awvalid, 0);
        check({tag, "_wvalid_drop"}, wvalid, 0);
        for (int i = 0; i < b_dly; i++) begin
            check({tag, "_bready_hold"}, bready, 1);
            check({tag, "_mvalid_early"}, Mvalid, 0);
            tick();
        end
        check({tag, "_bready"}, bready, 1);
        check({tag, "_mvalid_pre_b"}, Mvalid, 0);
        bvalid = 1'b1; bresp = resp;
        tick();
        bvalid = 1'b0; bresp = 2'b00;
        check({tag, "_bready_drop"}, bready, 0);
        check({tag, "_mvalid"}, Mvalid, 1);
        check({tag, "_result"}, MemResult, addr);
        check({tag, "_err"}, MemErr, exp_err);
        Wready = 1'b1;
        tick();
        Wready = 1'b0; MemWrite = 1'b0;
        check({tag, "_mvalid_end"}, Mvalid, 0);
        check({tag, "_mready_end"}, Mready, 1);
    endtask

    initial begin
        rstn = 1'b0; Evalid = 1'b0; ALUResult = 32'h0; WriteData = 32'h0;
        MemRead = 1'b0; MemWrite = 1'b0; MemOp = 3'b000; Wready = 1'b0;
        arready = 1'b0; rdata = 32'h0; rresp = 2'b00; rvalid = 1'b0;
        awready = 1'b0; wready = 1'b0; bresp = 2'b00; bvalid = 1'b0;
        tick();
        tick();
        check("rst_mready", Mready, 1);
        check("rst_mvalid", Mvalid, 0);
        check("rst_result", MemResult, 0);
        check("rst_err", MemErr, 0);
        check("rst_bus_valids", {arvalid, rready, awvalid, wvalid, bready}, 0);
        rstn = 1'b1;
        tick();

        // Non-memory op: one cycle to Mvalid, Mready held low through the Wready cycle.
        Evalid = 1'b1; ALUResult = 32'h0000_1234; MemOp = MemOpLw;
        tick();
        Evalid = 1'b0; ALUResult = 32'h0;
        check("alu_mvalid", Mvalid, 1);
        check("alu_result", MemResult, 32'h0000_1234);
        check("alu_mready_busy", Mready, 0);
        check("alu_no_bus", {arvalid, awvalid, wvalid}, 0);
        tick();
        check("alu_mvalid_hold", Mvalid, 1);
        check("alu_mready_hold", Mready, 0);
        Wready = 1'b1;
        tick();
        Wready = 1'b0;
        check("alu_mvalid_end", Mvalid, 0);
        check("alu_mready_end", Mready, 1);

        do_load("lb",  32'h8000_0003, MemOpLb,  1'b0, 32'h80FF_0000, 2'b00, 0, 0, 0, 1'b0,
                32'hFFFF_FF80, 1'b0);
        do_load("lbu", 32'h8000_0003, MemOpLbu, 1'b0, 32'h80FF_0000, 2'b00, 0, 0, 0, 1'b0,
                32'h0000_0080, 1'b0);
        do_load("lh",  32'h8000_0002, MemOpLh,  1'b0, 32'h80FF_0000, 2'b00, 1, 0, 0, 1'b0,
                32'hFFFF_80FF, 1'b0);
        do_load("lhu", 32'h8000_0000, MemOpLhu, 1'b0, 32'h1234_F00F, 2'b00, 0, 1, 0, 1'b0,
                32'h0000_F00F, 1'b0);
        do_load("lw_rw", 32'h8000_0004, MemOpLw, 1'b1, 32'hCAFE_BABE, 2'b00, 0, 0, 1, 1'b0,
                32'hCAFE_BABE, 1'b0);
        do_load("lw_rerr", 32'h8000_0004, MemOpLw, 1'b0, 32'h0BAD_F00D, 2'b11, 0, 0, 0, 1'b0,
                32'h0BAD_F00D, 1'b1);
        // Back-pressure with Evalid held high throughout.
        do_load("lw_bp", 32'h8000_0008, MemOpLw, 1'b0, 32'h1357_9BDF, 2'b00, 3, 4, 5, 1'b1,
                32'h1357_9BDF, 1'b0);

        do_store("sh_aw_first", 32'h8000_0002, MemOpSh, 32'hDEAD_BEEF, 0, 2, 0, 2'b00,
                 4'b1100, 32'hBEEF_BEEF, 1'b0);
        do_store("sh_w_first", 32'h8000_0002, MemOpSh, 32'hDEAD_BEEF, 2, 0, 1, 2'b00,
                 4'b1100, 32'hBEEF_BEEF, 1'b0);
        do_store("sb_same", 32'h8000_0001, MemOpSb, 32'h0000_00A5, 0, 0, 0, 2'b00,
                 4'b0010, 32'hA5A5_A5A5, 1'b0);
        do_store("sh_lo", 32'h8000_0000, MemOpSh, 32'h0000_1234, 1, 1, 0, 2'b00,
                 4'b0011, 32'h1234_1234, 1'b0);
        do_store("sw_berr", 32'h8000_0010, MemOpSw, 32'h1234_5678, 0, 0, 2, 2'b10,
                 4'b1111, 32'h1234_5678, 1'b1);

`ifdef YSYX_LSU_MISALIGN_EN
        Evalid = 1'b1; ALUResult = 32'h8000_0002; MemRead = 1'b1; MemOp = MemOpLw;
        tick();
        Evalid = 1'b0; MemRead = 1'b0;
        check("mis_arvalid", arvalid, 0);
        check("mis_mvalid", Mvalid, 1);
        check("mis_err", MemErr, 1);
        check("mis_result", MemResult, 0);
        Wready = 1'b1;
        tick();
        Wready = 1'b0;
        check("mis_mready_end", Mready, 1);
        check("mis_arvalid_end", arvalid, 0);
`else
        do_load("lh_mis", 32'h8000_0003, MemOpLh, 1'b0, 32'hABCD_1234, 2'b00, 0, 0, 0, 1'b0,
                32'hFFFF_ABCD, 1'b0);
        do_load("lw_mis", 32'h8000_0002, MemOpLw, 1'b0, 32'h1122_3344, 2'b00, 0, 0, 0, 1'b0,
                32'h1122_3344, 1'b0);
`endif

        // Asynchronous reset while waiting for read data.
        Evalid = 1'b1; ALUResult = 32'h8000_0008; MemRead = 1'b1; MemOp = MemOpLw;
        tick();
        Evalid = 1'b0; MemRead = 1'b0;
        arready = 1'b1;
        tick();
        arready = 1'b0;
        check("rst_rdata_rready", rready, 1);
        #2 rstn = 1'b0;
        #1;
        check("arst_rready", rready, 0);
        check("arst_arvalid", arvalid, 0);
        check("arst_mready", Mready, 1);
        check("arst_mvalid", Mvalid, 0);
        check("arst_result", MemResult, 0);
        tick();
        rstn = 1'b1;
        rvalid = 1'b1; rdata = 32'hFFFF_FFFF;
        tick();
        rvalid = 1'b0; rdata = 32'h0;
        check("post_rst_mready", Mready, 1);
        check("post_rst_mvalid", Mvalid, 0);
        check("post_rst_rready", rready, 0);

        Evalid = 1'b1; ALUResult = 32'h0000_00AB;
        tick();
        Evalid = 1'b0;
        check("post_rst_alu_mvalid", Mvalid, 1);
        check("post_rst_alu_result", MemResult, 32'h0000_00AB);
        Wready = 1'b1;
        tick();
        Wready = 1'b0;
        check("post_rst_alu_mready", Mready, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
